// File: rtl/param_issue_queue.sv
// param_issue_queue: age-ordered collapsing issue queue with CDB wakeup.
//   Slot 0 holds the oldest instruction; slots [0, count-1] are occupied.
//   The oldest entry with both operands valid is presented on the issue port.
//   It is removed on a clock edge where issueque_ready and issueblk_done are both high.
// Ports:
//   clk, reset (sync, active-low), flush (sync squash of all entries)
//   dispatch_*          : instruction entering the queue (accepted when not full)
//   cdb_valid/tag/data  : NUM_CDB packed broadcast ports used for operand wakeup
//   issueblk_done       : execution unit accepts the presented instruction
//   issueque_full/almost_full/count : occupancy status, from the registered count
//   issueque_ready/opcode/rd_tag/rs1_data/rs2_data : presented instruction
//                                                     (all zero when not ready)
module param_issue_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned OPC_W     = 4,
  parameter int unsigned NUM_CDB   = 2,
  parameter int unsigned AF_THRESH = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        dispatch_enable,
  input  logic [OPC_W-1:0]            dispatch_opcode,
  input  logic [TAG_W-1:0]            dispatch_rd_tag,
  input  logic [DATA_W-1:0]           dispatch_rs1_data,
  input  logic [TAG_W-1:0]            dispatch_rs1_tag,
  input  logic                        dispatch_rs1_valid,
  input  logic [DATA_W-1:0]           dispatch_rs2_data,
  input  logic [TAG_W-1:0]            dispatch_rs2_tag,
  input  logic                        dispatch_rs2_valid,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
  input  logic                        issueblk_done,
  output logic                        issueque_full,
  output logic                        issueque_almost_full,
  output logic [$clog2(DEPTH+1)-1:0]  issueque_count,
  output logic                        issueque_ready,
  output logic [OPC_W-1:0]            issueque_opcode,
  output logic [TAG_W-1:0]            issueque_rd_tag,
  output logic [DATA_W-1:0]           issueque_rs1_data,
  output logic [DATA_W-1:0]           issueque_rs2_data
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Entry storage
  logic [OPC_W-1:0]  opc_q      [DEPTH];
  logic [OPC_W-1:0]  opc_d      [DEPTH];
  logic [TAG_W-1:0]  rd_q       [DEPTH];
  logic [TAG_W-1:0]  rd_d       [DEPTH];
  logic [DATA_W-1:0] rs1_data_q [DEPTH];
  logic [DATA_W-1:0] rs1_data_d [DEPTH];
  logic [TAG_W-1:0]  rs1_tag_q  [DEPTH];
  logic [TAG_W-1:0]  rs1_tag_d  [DEPTH];
  logic              rs1_v_q    [DEPTH];
  logic              rs1_v_d    [DEPTH];
  logic [DATA_W-1:0] rs2_data_q [DEPTH];
  logic [DATA_W-1:0] rs2_data_d [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_q  [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_d  [DEPTH];
  logic              rs2_v_q    [DEPTH];
  logic              rs2_v_d    [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              any_rdy;
  logic [IDX_W-1:0]  sel;
  logic              issue_fire;
  logic              disp_acc;
  logic [CNT_W-1:0]  wr_idx;
  logic [DATA_W:0]   disp_rs1;
  logic [DATA_W:0]   disp_rs2;

  // Operand wakeup: returns {valid, data}; lowest matching CDB port wins.
  function automatic logic [DATA_W:0] wake(
    input logic                      v,
    input logic [TAG_W-1:0]          tag,
    input logic [DATA_W-1:0]         data,
    input logic [NUM_CDB-1:0]        cv,
    input logic [NUM_CDB*TAG_W-1:0]  ct,
    input logic [NUM_CDB*DATA_W-1:0] cd
  );
    logic [DATA_W:0] r;
    r = {v, data};
    if (!v) begin
      for (int p = NUM_CDB - 1; p >= 0; p--) begin
        if (cv[p] && (ct[p*TAG_W +: TAG_W] == tag)) begin
          r = {1'b1, cd[p*DATA_W +: DATA_W]};
        end
      end
    end
    return r;
  endfunction

  // Oldest-ready select from registered state only, so a wakeup issues next cycle.
  always_comb begin
    any_rdy = 1'b0;
    sel     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < cnt_q) && rs1_v_q[i] && rs2_v_q[i]) begin
        any_rdy = 1'b1;
        sel     = IDX_W'(i);
      end
    end
  end

  // Next state: collapse above the issued slot, wake every slot, append dispatch.
  always_comb begin
    issue_fire = any_rdy && issueblk_done;
    disp_acc   = dispatch_enable && !issueque_full;
    wr_idx     = cnt_q - CNT_W'(issue_fire);
    disp_rs1   = wake(dispatch_rs1_valid, dispatch_rs1_tag, dispatch_rs1_data,
                      cdb_valid, cdb_tag, cdb_data);
    disp_rs2   = wake(dispatch_rs2_valid, dispatch_rs2_tag, dispatch_rs2_data,
                      cdb_valid, cdb_tag, cdb_data);
    for (int i = 0; i < DEPTH; i++) begin
      int src;
      src = i;
      if (issue_fire && (IDX_W'(i) >= sel) && (i < DEPTH - 1)) src = i + 1;
      opc_d[i]     = opc_q[src];
      rd_d[i]      = rd_q[src];
      rs1_tag_d[i] = rs1_tag_q[src];
      rs2_tag_d[i] = rs2_tag_q[src];
      {rs1_v_d[i], rs1_data_d[i]} = wake(rs1_v_q[src], rs1_tag_q[src], rs1_data_q[src],
                                         cdb_valid, cdb_tag, cdb_data);
      {rs2_v_d[i], rs2_data_d[i]} = wake(rs2_v_q[src], rs2_tag_q[src], rs2_data_q[src],
                                         cdb_valid, cdb_tag, cdb_data);
      if (disp_acc && (CNT_W'(i) == wr_idx)) begin
        opc_d[i]     = dispatch_opcode;
        rd_d[i]      = dispatch_rd_tag;
        rs1_tag_d[i] = dispatch_rs1_tag;
        rs2_tag_d[i] = dispatch_rs2_tag;
        {rs1_v_d[i], rs1_data_d[i]} = disp_rs1;
        {rs2_v_d[i], rs2_data_d[i]} = disp_rs2;
      end
      if (flush) begin
        rs1_v_d[i] = 1'b0;
        rs2_v_d[i] = 1'b0;
      end
    end
    cnt_d = cnt_q + CNT_W'(disp_acc) - CNT_W'(issue_fire);
    if (flush) cnt_d = '0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opc_q[i]      <= '0;
        rd_q[i]       <= '0;
        rs1_data_q[i] <= '0;
        rs1_tag_q[i]  <= '0;
        rs1_v_q[i]    <= 1'b0;
        rs2_data_q[i] <= '0;
        rs2_tag_q[i]  <= '0;
        rs2_v_q[i]    <= 1'b0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        opc_q[i]      <= opc_d[i];
        rd_q[i]       <= rd_d[i];
        rs1_data_q[i] <= rs1_data_d[i];
        rs1_tag_q[i]  <= rs1_tag_d[i];
        rs1_v_q[i]    <= rs1_v_d[i];
        rs2_data_q[i] <= rs2_data_d[i];
        rs2_tag_q[i]  <= rs2_tag_d[i];
        rs2_v_q[i]    <= rs2_v_d[i];
      end
    end
  end

  assign issueque_count       = cnt_q;
  assign issueque_full        = (cnt_q == CNT_W'(DEPTH));
  assign issueque_almost_full = (32'(cnt_q) >= AF_THRESH);

  // Issue port, forced to zero when nothing is ready
  always_comb begin
    issueque_ready    = 1'b0;
    issueque_opcode   = '0;
    issueque_rd_tag   = '0;
    issueque_rs1_data = '0;
    issueque_rs2_data = '0;
    if (any_rdy) begin
      issueque_ready    = 1'b1;
      issueque_opcode   = opc_q[sel];
      issueque_rd_tag   = rd_q[sel];
      issueque_rs1_data = rs1_data_q[sel];
      issueque_rs2_data = rs2_data_q[sel];
    end
  end

endmodule

// File: tb/tb_param_issue_queue.sv
// Directed bench for param_issue_queue. The stimulus pushes the hand-computed
// expected issue stream into a queue. A negedge monitor pops from it and compares
// on every issue handshake, and checks that the issue port is zero while idle.
module tb_param_issue_queue;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned NUM_CDB = 2;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [TAG_W-1:0]  rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      flush;
  logic                      dispatch_enable;
  logic [OPC_W-1:0]          dispatch_opcode;
  logic [TAG_W-1:0]          dispatch_rd_tag;
  logic [DATA_W-1:0]         dispatch_rs1_data;
  logic [TAG_W-1:0]          dispatch_rs1_tag;
  logic                      dispatch_rs1_valid;
  logic [DATA_W-1:0]         dispatch_rs2_data;
  logic [TAG_W-1:0]          dispatch_rs2_tag;
  logic                      dispatch_rs2_valid;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic                      issueblk_done;
  logic                      issueque_full;
  logic                      issueque_almost_full;
  logic [CNT_W-1:0]          issueque_count;
  logic                      issueque_ready;
  logic [OPC_W-1:0]          issueque_opcode;
  logic [TAG_W-1:0]          issueque_rd_tag;
  logic [DATA_W-1:0]         issueque_rs1_data;
  logic [DATA_W-1:0]         issueque_rs2_data;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  param_issue_queue #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OPC_W(OPC_W),
    .NUM_CDB(NUM_CDB), .AF_THRESH(6)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_enable(dispatch_enable), .dispatch_opcode(dispatch_opcode),
    .dispatch_rd_tag(dispatch_rd_tag),
    .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs1_tag(dispatch_rs1_tag),
    .dispatch_rs1_valid(dispatch_rs1_valid),
    .dispatch_rs2_data(dispatch_rs2_data), .dispatch_rs2_tag(dispatch_rs2_tag),
    .dispatch_rs2_valid(dispatch_rs2_valid),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issueblk_done(issueblk_done),
    .issueque_full(issueque_full), .issueque_almost_full(issueque_almost_full),
    .issueque_count(issueque_count), .issueque_ready(issueque_ready),
    .issueque_opcode(issueque_opcode), .issueque_rd_tag(issueque_rd_tag),
    .issueque_rs1_data(issueque_rs1_data), .issueque_rs2_data(issueque_rs2_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare each handshake against the scoreboard, idle port must be zero.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (issueque_ready && issueblk_done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL issue_unexpected actual=%0h required=none",
                   {issueque_opcode, issueque_rd_tag, issueque_rs1_data, issueque_rs2_data});
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("issue", 128'({issueque_opcode, issueque_rd_tag,
                             issueque_rs1_data, issueque_rs2_data}), 128'(e));
        end
      end else if (!issueque_ready) begin
        chk("idle_zero", 128'({issueque_opcode, issueque_rd_tag,
                               issueque_rs1_data, issueque_rs2_data}), 128'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [OPC_W-1:0] opc, input logic [TAG_W-1:0] rd,
                      input logic [DATA_W-1:0] d1, input logic [TAG_W-1:0] t1, input logic v1,
                      input logic [DATA_W-1:0] d2, input logic [TAG_W-1:0] t2, input logic v2);
    dispatch_enable    = 1'b1;
    dispatch_opcode    = opc;
    dispatch_rd_tag    = rd;
    dispatch_rs1_data  = d1;
    dispatch_rs1_tag   = t1;
    dispatch_rs1_valid = v1;
    dispatch_rs2_data  = d2;
    dispatch_rs2_tag   = t2;
    dispatch_rs2_valid = v2;
  endtask

  task automatic idle_in();
    dispatch_enable    = 1'b0;
    dispatch_opcode    = '0;
    dispatch_rd_tag    = '0;
    dispatch_rs1_data  = '0;
    dispatch_rs1_tag   = '0;
    dispatch_rs1_valid = 1'b0;
    dispatch_rs2_data  = '0;
    dispatch_rs2_tag   = '0;
    dispatch_rs2_valid = 1'b0;
    cdb_valid          = '0;
    cdb_tag            = '0;
    cdb_data           = '0;
    issueblk_done      = 1'b0;
    flush              = 1'b0;
  endtask

  task automatic cdb(input int p, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid[p]                 = 1'b1;
    cdb_tag[p*TAG_W +: TAG_W]    = t;
    cdb_data[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic chk_status(input string name, input int cnt, input logic full,
                            input logic af, input logic rdy);
    chk(name, 128'({issueque_count, issueque_full, issueque_almost_full, issueque_ready}),
        128'({CNT_W'(cnt), full, af, rdy}));
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    tick();
    tick();
    // Reset state
    chk_status("reset_status", 0, 1'b0, 1'b0, 1'b0);
    chk("reset_outputs", 128'({issueque_opcode, issueque_rd_tag, issueque_rs1_data,
                               issueque_rs2_data}), 128'(0));
    reset = 1'b1;
    tick();

    // Single ready dispatch then issue
    disp(4'd3, 6'd5, 32'h10, 6'd0, 1'b1, 32'h20, 6'd0, 1'b1);
    exp_q.push_back('{4'd3, 6'd5, 32'h10, 32'h20});
    tick();
    idle_in();
    chk_status("t1_after_dispatch", 1, 1'b0, 1'b0, 1'b1);
    chk("t1_data", 128'({issueque_rs1_data, issueque_rs2_data}), 128'({32'h10, 32'h20}));
    issueblk_done = 1'b1;
    tick();
    idle_in();
    chk_status("t1_after_issue", 0, 1'b0, 1'b0, 1'b0);

    // Wakeup through CDB port 1; port 0 carries an unrelated tag
    disp(4'd1, 6'd7, 32'hDEAD, 6'd9, 1'b0, 32'h55, 6'd0, 1'b1);
    exp_q.push_back('{4'd1, 6'd7, 32'hABCD, 32'h55});
    tick();
    idle_in();
    chk_status("t2_waiting", 1, 1'b0, 1'b0, 1'b0);
    tick();
    cdb(0, 6'd3, 32'h1111);
    cdb(1, 6'd9, 32'hABCD);
    #1;
    chk("t2_no_same_cycle_issue", 128'(issueque_ready), 128'(0));
    tick();
    idle_in();
    chk_status("t2_woken", 1, 1'b0, 1'b0, 1'b1);
    chk("t2_rs1", 128'(issueque_rs1_data), 128'(32'hABCD));
    issueblk_done = 1'b1;
    tick();
    idle_in();

    // Fill to full, then a dropped dispatch alongside an issue
    for (int i = 0; i < 8; i++) begin
      disp(4'(i), 6'(16 + i), 32'h100 + 32'(i), 6'd0, 1'b1, 32'h200 + 32'(i), 6'd0, 1'b1);
      exp_q.push_back('{4'(i), 6'(16 + i), 32'h100 + 32'(i), 32'h200 + 32'(i)});
      tick();
      if (i == 4) chk_status("t3_count5", 5, 1'b0, 1'b0, 1'b1);
      if (i == 5) chk_status("t3_count6_af", 6, 1'b0, 1'b1, 1'b1);
    end
    idle_in();
    chk_status("t3_full", 8, 1'b1, 1'b1, 1'b1);
    disp(4'hF, 6'h3F, 32'hBAD0, 6'd0, 1'b1, 32'hBAD1, 6'd0, 1'b1);
    issueblk_done = 1'b1;
    tick();
    idle_in();
    chk_status("t3_ninth_dropped", 7, 1'b0, 1'b1, 1'b1);
    issueblk_done = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    idle_in();
    chk_status("t3_drained", 0, 1'b0, 1'b0, 1'b0);

    // Oldest-ready select skips a waiting entry, which is retained
    disp(4'd2, 6'd1, 32'h11, 6'd0, 1'b1, 32'h12, 6'd0, 1'b1);
    exp_q.push_back('{4'd2, 6'd1, 32'h11, 32'h12});
    tick();
    disp(4'd3, 6'd2, 32'h31, 6'd0, 1'b1, 32'h0, 6'd12, 1'b0);
    tick();
    disp(4'd4, 6'd3, 32'h41, 6'd0, 1'b1, 32'h42, 6'd0, 1'b1);
    exp_q.push_back('{4'd4, 6'd3, 32'h41, 32'h42});
    tick();
    idle_in();
    chk_status("t4_three", 3, 1'b0, 1'b0, 1'b1);
    issueblk_done = 1'b1;
    tick();
    chk("t4_sel_slot1", 128'(issueque_rd_tag), 128'(6'd3));
    tick();
    tick();
    idle_in();
    chk_status("t4_retained", 1, 1'b0, 1'b0, 1'b0);

    // Issue with shift-in wakeup, plus same-cycle dispatch with CDB bypass
    disp(4'd5, 6'd4, 32'h51, 6'd0, 1'b1, 32'h52, 6'd0, 1'b1);
    exp_q.push_back('{4'd5, 6'd4, 32'h51, 32'h52});
    tick();
    disp(4'd6, 6'd5, 32'h0, 6'd13, 1'b0, 32'h62, 6'd0, 1'b1);
    tick();
    idle_in();
    chk_status("t5_three", 3, 1'b0, 1'b0, 1'b1);
    disp(4'd7, 6'd6, 32'h0, 6'd13, 1'b0, 32'h0, 6'd12, 1'b0);
    cdb(0, 6'd13, 32'h5151);
    cdb(1, 6'd12, 32'h1212);
    issueblk_done = 1'b1;
    exp_q.push_back('{4'd3, 6'd2, 32'h31, 32'h1212});
    exp_q.push_back('{4'd6, 6'd5, 32'h5151, 32'h62});
    exp_q.push_back('{4'd7, 6'd6, 32'h5151, 32'h1212});
    tick();
    idle_in();
    chk_status("t5_issue_plus_dispatch", 3, 1'b0, 1'b0, 1'b1);
    issueblk_done = 1'b1;
    tick();
    tick();
    tick();
    idle_in();
    chk_status("t5_drained", 0, 1'b0, 1'b0, 1'b0);

    // Two ports match the same tag: port 0 wins
    disp(4'd8, 6'd9, 32'h0, 6'd20, 1'b0, 32'h0, 6'd20, 1'b0);
    exp_q.push_back('{4'd8, 6'd9, 32'hAAAA, 32'hAAAA});
    tick();
    idle_in();
    cdb(0, 6'd20, 32'hAAAA);
    cdb(1, 6'd20, 32'hBBBB);
    tick();
    idle_in();
    chk("t6_port0_wins", 128'({issueque_rs1_data, issueque_rs2_data}),
        128'({32'hAAAA, 32'hAAAA}));
    issueblk_done = 1'b1;
    tick();
    idle_in();

    // Flush overrides a simultaneous dispatch
    for (int i = 0; i < 4; i++) begin
      disp(4'(i), 6'(40 + i), 32'(i), 6'd0, 1'b1, 32'(i), 6'd0, 1'b1);
      tick();
    end
    idle_in();
    chk_status("t7_four", 4, 1'b0, 1'b0, 1'b1);
    disp(4'd9, 6'd9, 32'h9, 6'd0, 1'b1, 32'h9, 6'd0, 1'b1);
    flush = 1'b1;
    tick();
    idle_in();
    chk_status("t7_flushed", 0, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation with CDB activity, then a fresh dispatch
    for (int i = 0; i < 5; i++) begin
      disp(4'(i), 6'(50 + i), 32'h0, 6'd30, 1'b0, 32'h0, 6'd30, 1'b0);
      tick();
    end
    idle_in();
    chk_status("t8_five", 5, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cdb(0, 6'd30, 32'h3030);
    disp(4'd1, 6'd1, 32'h1, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1);
    issueblk_done = 1'b1;
    tick();
    reset = 1'b1;
    idle_in();
    chk_status("t8_reset", 0, 1'b0, 1'b0, 1'b0);
    chk("t8_outputs", 128'({issueque_opcode, issueque_rd_tag, issueque_rs1_data,
                            issueque_rs2_data}), 128'(0));
    tick();
    chk_status("t8_stays_empty", 0, 1'b0, 1'b0, 1'b0);
    disp(4'hF, 6'h3F, 32'hFFFF_FFFF, 6'd0, 1'b1, 32'h8000_0001, 6'd0, 1'b1);
    exp_q.push_back('{4'hF, 6'h3F, 32'hFFFF_FFFF, 32'h8000_0001});
    tick();
    idle_in();
    chk_status("t8_after_reset_dispatch", 1, 1'b0, 1'b0, 1'b1);
    issueblk_done = 1'b1;
    tick();
    idle_in();
    chk_status("t8_final", 0, 1'b0, 1'b0, 1'b0);
    tick();

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
